// File: rtl/prio_irq_pkg.sv
// rtl/prio_irq_pkg.sv - shared constants and helpers for the priority interrupt encoder
// Contents: DEFAULT_N, DEFAULT_LOST_W, clog2_min1() (index width, never below 1 bit).
package prio_irq_pkg;

  localparam int DEFAULT_N      = 9;
  localparam int DEFAULT_LOST_W = 8;

  // A 2-line encoder still needs one index bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_irq_encoder_if.sv
// rtl/prio_irq_encoder_if.sv - valid/ready index handshake between encoder and consumer
// Signals: valid (index presented), ready (consumer accepts), idx (encoded index),
//          idx_n (bitwise inverse of idx).
// Modports: master = encoder side, slave = consumer side.
interface prio_irq_encoder_if
  import prio_irq_pkg::*;
#(
  parameter int IDX_W = clog2_min1(DEFAULT_N)
);

  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_n;

  modport master (output valid, output idx, output idx_n, input ready);
  modport slave  (input valid, input idx, input idx_n, output ready);

endinterface

// File: rtl/prio_irq_encoder_pick.sv
// rtl/prio_irq_encoder_pick.sv - combinational descending search with wraparound
// Ports: vec   in  N      candidate lines
//        start in  IDX_W  first index examined; search descends and wraps N-1 after 0
//        any   out 1      at least one candidate present
//        sel   out IDX_W  first candidate found
module prio_pick
  import prio_irq_pkg::*;
#(
  parameter  int N     = DEFAULT_N,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             any,
  output logic [IDX_W-1:0] sel
);

  // Walk from the lowest priority position up to start so the last hit
  // written is the one closest to start.
  always_comb begin : search
    int               j;
    logic [IDX_W-1:0] pos;
    any = 1'b0;
    sel = '0;
    j   = 0;
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(start) - i;
      if (j < 0) j = j + N;
      pos = IDX_W'(j);
      if (vec[pos]) begin
        any = 1'b1;
        sel = pos;
      end
    end
  end

endmodule

// File: rtl/prio_irq_encoder.sv
// rtl/prio_irq_encoder.sv - registered N-line active-low priority encoder with sticky pending
// Ports: clk      in  1       rising-edge clock
//        rst_n    in  1       asynchronous active-low reset
//        req_n    in  N       active-low request lines, falling edge raises a request
//        mask     in  N       1 = line not selectable, pending still captured
//        bus      master      valid/ready/idx/idx_n handshake
//        pending  out N       sticky pending vector
//        lost_cnt out LOST_W  saturating count of edges on already-pending lines
// Option: PRIO_IRQ_ENCODER_RR_EN selects rotating priority instead of fixed (N-1 highest).
module prio_irq_encoder
  import prio_irq_pkg::*;
#(
  parameter  int N      = DEFAULT_N,
  parameter  int LOST_W = DEFAULT_LOST_W,
  localparam int IDX_W  = clog2_min1(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_n,
  input  logic [N-1:0]        mask,
  prio_irq_encoder_if.master  bus,
  output logic [N-1:0]        pending,
  output logic [LOST_W-1:0]   lost_cnt
);

  logic [N-1:0]     req_q;
  logic [N-1:0]     fall;
  logic [N-1:0]     clr;
  logic [N-1:0]     elig;
  logic [N-1:0]     pend_nxt;
  logic             hs;
  logic             lost_any;
  logic             load;
  logic             pick_any;
  logic [IDX_W-1:0] pick_sel;
  logic [IDX_W-1:0] start;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;

  assign hs       = valid_q & bus.ready;
  assign fall     = req_q & ~req_n;
  assign clr      = hs ? (N'(1) << idx_q) : '0;
  // A new edge on the line being granted re-pends it (set beats clear).
  assign pend_nxt = (pending & ~clr) | fall;
  assign lost_any = |(fall & pending & ~clr);
  // The line handed over this cycle must not be picked again.
  assign elig     = pending & ~mask & ~clr;
  assign load     = ~valid_q | hs;

`ifdef PRIO_IRQ_ENCODER_RR_EN
  logic [IDX_W-1:0] ptr;

  assign start = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDX_W'(N - 1);
    end else if (load && pick_any) begin
      ptr <= (pick_sel == '0) ? IDX_W'(N - 1) : pick_sel - IDX_W'(1);
    end
  end
`else
  assign start = IDX_W'(N - 1);
`endif

  prio_pick #(.N(N)) u_pick (
    .vec   (elig),
    .start (start),
    .any   (pick_any),
    .sel   (pick_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '1;
      pending  <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      lost_cnt <= '0;
    end else begin
      req_q   <= req_n;
      pending <= pend_nxt;
      if (load) begin
        valid_q <= pick_any;
        if (pick_any) idx_q <= pick_sel;
      end
      if (lost_any && (lost_cnt != '1)) lost_cnt <= lost_cnt + LOST_W'(1);
    end
  end

  assign bus.valid = valid_q;
  assign bus.idx   = idx_q;
  assign bus.idx_n = ~idx_q;

endmodule

// File: tb/tb_prio_irq_encoder.sv
// tb/tb_prio_irq_encoder.sv - self-checking bench for prio_irq_encoder (N = 9)
module tb_prio_irq_encoder;
  import prio_irq_pkg::*;

  localparam int N      = 9;
  localparam int IDX_W  = 4;
  localparam int LOST_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_n;
  logic [N-1:0]      mask;
  logic [N-1:0]      pending;
  logic [LOST_W-1:0] lost_cnt;

  prio_irq_encoder_if #(.IDX_W(IDX_W)) bus ();

  prio_irq_encoder #(.N(N), .LOST_W(LOST_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_n    (req_n),
    .mask     (mask),
    .bus      (bus),
    .pending  (pending),
    .lost_cnt (lost_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: integer-indexed lines, priority search by modular walk.
  bit m_req_q[N];
  bit m_pend[N];
  bit m_valid;
  int m_idx;
  int m_lost;
  int m_ptr;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_req_q[i] = 1'b1;
      m_pend[i]  = 1'b0;
    end
    m_valid = 1'b0;
    m_idx   = 0;
    m_lost  = 0;
    m_ptr   = N - 1;
  endtask

  task automatic model_step();
    int granted;
    int start;
    int line;
    bit found;
    bit lost;
    bit f;
    bit np[N];
    granted = (m_valid && bus.ready) ? m_idx : -1;
    lost = 1'b0;
    for (int i = 0; i < N; i++) begin
      f = m_req_q[i] && !req_n[i];
      if (f && m_pend[i] && i != granted) lost = 1'b1;
      np[i] = f || (m_pend[i] && i != granted);
    end
    if (!m_valid || granted >= 0) begin
`ifdef PRIO_IRQ_ENCODER_RR_EN
      start = m_ptr;
`else
      start = N - 1;
`endif
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        line = (start - k + N) % N;
        if (!found && m_pend[line] && !mask[line] && line != granted) begin
          found = 1'b1;
          m_idx = line;
          m_ptr = (line + N - 1) % N;
        end
      end
      m_valid = found;
    end
    if (lost && m_lost < (1 << LOST_W) - 1) m_lost++;
    for (int i = 0; i < N; i++) begin
      m_pend[i]  = np[i];
      m_req_q[i] = req_n[i];
    end
  endtask

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_model();
    check("rand_valid", bus.valid, m_valid);
    if (m_valid) begin
      check("rand_idx", bus.idx, m_idx);
      check("rand_idx_n", bus.idx_n, (~m_idx) & 4'hF);
    end
    check("rand_pending", pending, model_pend());
    check("rand_lost", lost_cnt, m_lost);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_n     = '1;
    mask      = '0;
    bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0]     req_n;
    logic [N-1:0]     mask;
    logic             ready;
    logic             exp_valid;
    logic [IDX_W-1:0] exp_idx;
    logic [N-1:0]     exp_pend;
  } vec_t;

  vec_t tbl[9];

  initial begin
    // Lines 3 and 7 fall together, held with ready low, then drained.
    tbl[0] = '{9'h177, 9'h000, 1'b0, 1'b0, 4'd0, 9'h088};
    tbl[1] = '{9'h177, 9'h000, 1'b0, 1'b1, 4'd7, 9'h088};
    tbl[2] = '{9'h177, 9'h000, 1'b0, 1'b1, 4'd7, 9'h088};
    tbl[3] = '{9'h177, 9'h000, 1'b0, 1'b1, 4'd7, 9'h088};
    tbl[4] = '{9'h177, 9'h000, 1'b0, 1'b1, 4'd7, 9'h088};
    tbl[5] = '{9'h177, 9'h000, 1'b0, 1'b1, 4'd7, 9'h088};
    tbl[6] = '{9'h177, 9'h000, 1'b1, 1'b1, 4'd3, 9'h008};
    tbl[7] = '{9'h177, 9'h000, 1'b1, 1'b0, 4'd0, 9'h000};
    tbl[8] = '{9'h1FF, 9'h000, 1'b1, 1'b0, 4'd0, 9'h000};

    do_reset();
    check("reset_valid", bus.valid, 1'b0);
    check("reset_idx", bus.idx, 4'h0);
    check("reset_idx_n", bus.idx_n, 4'hF);
    check("reset_pending", pending, 9'h000);
    check("reset_lost", lost_cnt, 8'h00);

    // Idle
    bus.ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_valid", bus.valid, 1'b0);
      check("idle_idx_n", bus.idx_n, 4'hF);
      check("idle_lost", lost_cnt, 8'h00);
    end

    for (int i = 0; i < 9; i++) begin
      req_n     = tbl[i].req_n;
      mask      = tbl[i].mask;
      bus.ready = tbl[i].ready;
      tick();
      check($sformatf("tbl%0d_valid", i), bus.valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_idx", i), bus.idx, tbl[i].exp_idx);
      check($sformatf("tbl%0d_pending", i), pending, tbl[i].exp_pend);
    end

    // Hold stability: idx 2 stays presented while line 8 arrives.
    bus.ready = 1'b0;
    req_n = 9'h1FB;
    tick();
    check("hold_pend2", pending, 9'h004);
    tick();
    check("hold_valid", bus.valid, 1'b1);
    check("hold_idx2a", bus.idx, 4'd2);
    req_n = 9'h0FB;
    tick();
    check("hold_idx2b", bus.idx, 4'd2);
    check("hold_pend", pending, 9'h104);
    tick();
    check("hold_idx2c", bus.idx, 4'd2);
    bus.ready = 1'b1;
    tick();
    check("hold_next_valid", bus.valid, 1'b1);
    check("hold_next_idx8", bus.idx, 4'd8);
    tick();
    check("hold_drain", bus.valid, 1'b0);
    req_n = 9'h1FF;
    tick();

    // Masked line is captured but not presented until unmasked.
    mask  = 9'h020;
    req_n = 9'h1DF;
    tick();
    tick();
    check("mask_pend5", pending[5], 1'b1);
    check("mask_valid", bus.valid, 1'b0);
    mask = 9'h000;
    tick();
    check("unmask_valid", bus.valid, 1'b1);
    check("unmask_idx5", bus.idx, 4'd5);
    tick();
    check("unmask_drain", bus.valid, 1'b0);
    req_n = 9'h1FF;
    tick();

    // Lost-edge counting and saturation on line 0.
    do_reset();
    req_n = 9'h1FE;
    tick();
    for (int r = 0; r < 3; r++) begin
      req_n = 9'h1FF;
      tick();
      req_n = 9'h1FE;
      tick();
    end
    check("lost_3", lost_cnt, 8'd3);
    check("lost_idx0", bus.idx, 4'd0);
    for (int r = 0; r < 300; r++) begin
      req_n = 9'h1FF;
      tick();
      req_n = 9'h1FE;
      tick();
    end
    check("lost_sat", lost_cnt, 8'd255);
    check("lost_pend0", pending, 9'h001);

    // Reset dropped in the middle of an accepting cycle.
    bus.ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", bus.valid, 1'b0);
    check("midrst_pending", pending, 9'h000);
    check("midrst_lost", lost_cnt, 8'h00);
    check("midrst_idx_n", bus.idx_n, 4'hF);
    req_n = 9'h1FF;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    check("postrst_valid", bus.valid, 1'b0);
    check("postrst_pending", pending, 9'h000);

`ifdef PRIO_IRQ_ENCODER_RR_EN
    // Rotating priority: 8, 4, 1, then a search from 0 wraps to 8.
    do_reset();
    bus.ready = 1'b1;
    req_n = 9'h0ED;
    tick();
    tick();
    check("rr_first8", bus.idx, 4'd8);
    req_n = 9'h1FD;
    tick();
    check("rr_second4", bus.idx, 4'd4);
    tick();
    check("rr_third1", bus.idx, 4'd1);
    req_n = 9'h0ED;
    tick();
    check("rr_gap", bus.valid, 1'b0);
    tick();
    check("rr_wrap8", bus.idx, 4'd8);
    tick();
    check("rr_then4", bus.idx, 4'd4);
    req_n = 9'h1FF;
    tick();
    tick();
`endif

    // Randomised traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 3) == 0) req_n[b] = ~req_n[b];
      end
      bus.ready = ($urandom_range(0, 3) != 0);
      if (c % 50 == 0) mask = N'($urandom) & N'($urandom);
      tick();
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_irq_encoder.md
Name: prio_irq_encoder

Overview:
- Parametrised, registered successor to the 9-input active-low priority encoder.
- Captures falling edges on N active-low request lines into sticky pending bits and applies a per-line mask.
- Presents the highest-priority eligible index through a valid/ready handshake and counts lost (coalesced) edges.
- Sits between peripheral request lines and the consumer of the encoded index, typically an interrupt controller.

Parameters:
- N, 9, number of request lines (2..64); line N-1 has the highest fixed priority.
- IDX_W, $clog2(N), index width; derived, not overridden.
- LOST_W, 8, width of the saturating lost-edge counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_n  in  N  request lines, active-low; a falling edge raises a request. Already synchronous to clk.
- mask  in  N  1 = line blocked from selection; its pending bit is still captured and kept.
- valid  out  1  idx holds a granted request.
- ready  in  1  consumer accepts idx when valid && ready.
- idx  out  IDX_W  encoded index of the presented request.
- idx_n  out  IDX_W  bitwise inverse of idx, kept for compatibility with the active-low encoder output style.
- pending  out  N  current sticky pending vector.
- lost_cnt  out  LOST_W  saturating count of edges that arrived on an already-pending line.

Behaviour:
- Reset (async assert, sync release):
  - req_q = all 1s; pending = 0; valid = 0; idx = 0; idx_n = all 1s; lost_cnt = 0.
  - The rotate pointer (optional feature) resets to N-1.
- Edge detect:
  - req_q <= req_n every cycle.
  - fall[i] = req_q[i] & ~req_n[i].
  - A line held low without a new edge never re-pends.
- Pending update, per bit, each cycle:
  - Clear if a handshake occurs this cycle on idx == i.
  - Set if fall[i].
  - Set wins over clear in the same cycle.
- Lost edges:
  - fall[i] while pending[i] is already 1 and not being cleared this cycle increments lost_cnt by 1 per cycle, however many lines collide.
  - lost_cnt saturates at all 1s.
- Eligibility:
  - elig = pending & ~mask.
  - On a handshake cycle, also remove the bit being granted so it is never granted twice.
- Output register:
  - Loads when !valid, or when valid && ready.
  - On load: if elig != 0, then valid <= 1 and idx <= highest set index of elig; else valid <= 0.
- Stability:
  - While valid && !ready, idx and valid hold, even if a higher-priority request arrives or the held line becomes masked.
  - No retraction of a presented index.
- Latency:
  - Edge sampled at clock k: pending visible after k; valid and idx visible after k+1 (2 cycles from req_n low to valid).
  - Back-to-back grants are possible, one per cycle, while ready = 1.
- Boundaries:
  - All lines masked: valid = 0 and pending accumulates.
  - Unmasking later loads the output on the next cycle.
  - Reset asserted mid-handshake drops everything with no partial grant.

Optional Feature:
- PRIO_IRQ_ENCODER_RR_EN defined: rotating priority.
  - After granting index k, the search starts at (k-1) mod N and descends with wraparound.
  - Pointer resets to N-1.
- Undefined: fixed priority, N-1 highest; no pointer register is present.

Decomposition:
- Package prio_irq_pkg holds:
  - DEFAULT_N = 9, DEFAULT_LOST_W = 8.
  - A function clog2_min1 returning at least 1.
- Sub-module prio_pick: combinational, with inputs vec[N] and start[IDX_W], outputs any and sel[IDX_W].
  - Descending search from start with wraparound.
  - The fixed-priority build ties start to N-1.

Test Plan (N = 9, fixed priority unless stated):
- Reset then idle: req_n = 9'h1FF, ready = 1 -> valid = 0, idx_n = 4'hF, lost_cnt = 0 for 20 cycles.
- Drop req_n[3] and req_n[7] in the same cycle, ready = 0 -> valid after 2 cycles with idx = 7; hold 5 cycles, then ready = 1 -> idx = 7 then idx = 3 on consecutive cycles, then valid = 0.
- Hold stability: idx = 2 presented with ready = 0, then a falling edge on line 8 -> idx stays 2 until accepted; next grant is 8.
- Mask: mask[5] = 1, falling edge on line 5 -> pending[5] = 1, valid = 0; clear mask -> valid with idx = 5 one cycle later.
- Lost count: three re-edges on pending line 0 while ready = 0 -> lost_cnt = 3; 300 further collisions -> lost_cnt = 255.
- With PRIO_IRQ_ENCODER_RR_EN: lines 8, 4 and 1 all pending, ready = 1 -> grant order 8, 4, 1; re-raise 8 and 4 after granting 1 -> next grant 8 (search from 0 wraps to 8).
